circular_shift_sequencer: RTL and testbench

CIRCULAR_SHIFT_SEQUENCER -- requirements
Module: circular_shift_sequencer

---
 rtl/circular_shift_pkg.sv | 15 +
 rtl/circular_rotate_by_one.sv | 18 +
 rtl/circular_shift_sequencer.sv | 101 ++++++++++
 tb/tb_circular_shift_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/circular_shift_pkg.sv
// Shared types and constants for the circular shift sequencer.
package circular_shift_pkg;

  // Controller states: wait for a request, rotate one step per cycle, hold result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  // Direction encoding on up_dir.
  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

endpackage

// File: rtl/circular_rotate_by_one.sv
// Single-position circular rotate, left or right, purely combinational.
module circular_rotate_by_one
  import circular_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] din,
  input  logic         dir,
  output logic [N-1:0] dout
);

  // Left moves the MSB into bit 0; right moves the LSB into the MSB.
  always_comb begin
    if (dir == ROT_RIGHT) dout = {din[0], din[N-1:1]};
    else                  dout = {din[N-2:0], din[N-1]};
  end

endmodule

// File: rtl/circular_shift_sequencer.sv
// Multi-cycle circular rotator: accepts an operand, rotates it one bit per
// cycle for the requested amount, then presents the result until consumed.
module circular_shift_sequencer
  import circular_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [AW-1:0] up_amount,
  input  logic          up_dir,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic          busy
);

  // Width must be a power of two so AW bits cover exactly 0..N-1.
  generate
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("circular_shift_sequencer: N must be a power of two >= 2");
    end
  endgenerate

  seq_state_e    state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          down_valid_q, down_valid_d;
  logic [N-1:0]  down_data_q, down_data_d;
  logic [N-1:0]  rot_data;

  // The one rotator always looks at the data register in the latched direction.
  circular_rotate_by_one #(.N(N)) u_rot (
    .din  (data_q),
    .dir  (dir_q),
    .dout (rot_data)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (up_valid && up_ready) begin
          data_d  = up_data;
          cnt_d   = up_amount;
          dir_d   = up_dir;
          state_d = (up_amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = rot_data;
        cnt_d  = cnt_q - AW'(1);
        // Leave on the 1 -> 0 step so the count never wraps.
        if (cnt_q == AW'(1)) state_d = DONE;
      end
      DONE: begin
        if (down_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it;
    // the result bus is forced to zero whenever it is not valid.
    down_valid_d = (state_d == DONE);
    down_data_d  = down_valid_d ? data_d : '0;
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      cnt_q        <= '0;
      dir_q        <= ROT_LEFT;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
    end
  end

  // up_ready is masked by rst directly so nothing is offered while reset is held.
  assign up_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;

endmodule

// File: tb/tb_circular_shift_sequencer.sv
// Self-checking bench: directed vector table, reset/backpressure sequences,
// and randomized operations against a rotation/latency reference model.
module tb_circular_shift_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [AW-1:0] up_amount;
  logic          up_dir;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  circular_shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amount  (up_amount),
    .up_dir     (up_dir),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  d;
    logic [AW-1:0] k;
    logic          dir;
    int            hold;
    logic [N-1:0]  exp_data;
    int            exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference rotation: rotate a doubled word and take the window.
  function automatic logic [N-1:0] ref_rot(input logic [N-1:0] x, input int k, input logic dir);
    logic [2*N-1:0] w;
    w = {x, x};
    if (!dir) begin
      w = w << k;
      return w[2*N-1:N];
    end else begin
      w = w >> k;
      return w[N-1:0];
    end
  endfunction

  // Runs one operation from a negedge; returns the result and latency in cycles
  // after the handshake cycle (0 means timeout). Ends on a negedge, in IDLE.
  task automatic do_op(input logic [N-1:0] d, input logic [AW-1:0] k, input logic dir,
                       input int hold, input string tag,
                       output logic [N-1:0] res, output int lat);
    bit wait_ok;
    bit got_ready;
    got_ready = 0;
    for (int i = 0; i < 20; i++) begin
      if (up_ready) begin got_ready = 1; break; end
      @(negedge clk);
    end
    check({tag, " up_ready before request"}, 32'(got_ready), 32'd1);
    up_valid = 1'b1; up_data = d; up_amount = k; up_dir = dir; down_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    up_valid = 1'b0;
    lat = 0;
    wait_ok = 1;
    for (int c = 1; c <= 40; c++) begin
      if (down_valid) begin lat = c; break; end
      if (!busy || up_ready || down_data != '0) wait_ok = 0;
      // Inputs wander while in flight; they must not disturb the operation.
      up_data = N'($urandom); up_amount = AW'($urandom); up_dir = 1'($urandom);
      @(negedge clk);
    end
    check({tag, " busy/ready/zero data while shifting"}, 32'(wait_ok), 32'd1);
    res = down_data;
    if (lat == 0) begin
      check({tag, " timeout waiting down_valid"}, 32'd0, 32'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold down_valid"}, 32'(down_valid), 32'd1);
      check({tag, " hold down_data"}, 32'(down_data), 32'(res));
      check({tag, " hold up_ready"}, 32'(up_ready), 32'd0);
    end
    down_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    down_ready = 1'b0;
    check({tag, " post-handshake down_valid"}, 32'(down_valid), 32'd0);
    check({tag, " post-handshake down_data"}, 32'(down_data), 32'd0);
    check({tag, " post-handshake busy/up_ready"}, {30'd0, busy, up_ready}, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [N-1:0] res;
    int lat;
    bit quiet;

    vecs[0] = '{8'b10110101, 3'd3, 1'b0, 0, 8'b10101101, 4};
    vecs[1] = '{8'b10110101, 3'd3, 1'b1, 0, 8'b10110110, 4};
    vecs[2] = '{8'b01100110, 3'd3, 1'b1, 0, 8'b11001100, 4};
    vecs[3] = '{8'b11010001, 3'd0, 1'b0, 0, 8'b11010001, 1};
    vecs[4] = '{8'b00000001, 3'd7, 1'b0, 5, 8'b10000000, 8};
    vecs[5] = '{8'b00000001, 3'd7, 1'b1, 0, 8'b00000010, 8};
    vecs[6] = '{8'b10000000, 3'd1, 1'b0, 2, 8'b00000001, 2};

    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_amount = '0; up_dir = 1'b0;
    down_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset up_ready", 32'(up_ready), 32'd0);
    check("reset down_valid", 32'(down_valid), 32'd0);
    check("reset down_data", 32'(down_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("up_ready after reset release", 32'(up_ready), 32'd1);
    @(negedge clk);

    // Directed table; entries run back to back.
    foreach (vecs[i]) begin
      do_op(vecs[i].d, vecs[i].k, vecs[i].dir, vecs[i].hold, $sformatf("vec%0d", i), res, lat);
      check($sformatf("vec%0d data", i), 32'(res), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Reset pulse in the middle of an amount-5 operation.
    up_valid = 1'b1; up_data = 8'h5A; up_amount = 3'd5; up_dir = 1'b0;
    @(posedge clk);
    @(negedge clk);
    up_valid = 1'b0;
    @(negedge clk);
    check("mid-shift busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("up_ready while rst", 32'(up_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after abort busy", 32'(busy), 32'd0);
    check("after abort down_valid", 32'(down_valid), 32'd0);
    check("after abort down_data", 32'(down_data), 32'd0);
    check("after abort up_ready", 32'(up_ready), 32'd1);
    quiet = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (down_valid || busy) quiet = 1'b0;
    end
    check("no result after abort", 32'(quiet), 32'd1);
    do_op(8'b11100001, 3'd5, 1'b1, 1, "post-abort", res, lat);
    check("post-abort data", 32'(res), 32'(ref_rot(8'b11100001, 5, 1'b1)));
    check("post-abort latency", 32'(lat), 32'd6);

    // Randomized operations against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0]  d;
      logic [AW-1:0] k;
      logic          dir;
      d = N'($urandom); k = AW'($urandom); dir = 1'($urandom);
      do_op(d, k, dir, $urandom_range(0, 3), $sformatf("rand%0d", r), res, lat);
      check($sformatf("rand%0d data", r), 32'(res), 32'(ref_rot(d, int'(k), dir)));
      check($sformatf("rand%0d latency", r), 32'(lat), 32'(int'(k) + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
